// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding word-addressed memory request,
// a single-entry holding slot toward decode, and redirect/discard handling.
module fetch_stage #(
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [SIZE-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [SIZE-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [SIZE-1:0] if_instr,
    output logic [SIZE-1:0] if_pc,
    output logic [SIZE-1:0] if_pc_next,
    output logic [SIZE-1:0] fetch_count
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [SIZE-1:0] r_pc;
    logic            r_imem_req;
    logic [SIZE-1:0] r_imem_addr;
    logic            r_if_valid;
    logic [SIZE-1:0] r_if_instr;
    logic [SIZE-1:0] r_if_pc;
    logic [SIZE-1:0] r_if_pc_next;
    logic [SIZE-1:0] r_fetch_count;

    logic [SIZE-1:0] w_pc_next;
    logic            w_imem_req_next;
    logic [SIZE-1:0] w_imem_addr_next;
    logic            w_if_valid_next;
    logic [SIZE-1:0] w_if_instr_next;
    logic [SIZE-1:0] w_if_pc_next_next;
    logic [SIZE-1:0] w_if_pc_reg_next;
    logic [SIZE-1:0] w_fetch_count_next;
    logic [SIZE-1:0] w_pc_inc;
    logic [SIZE-1:0] w_drop_sel;

    assign w_pc_inc   = r_pc + ONE;
    assign w_drop_sel = redirect_valid ? redirect_target : r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: begin
                if (redirect_valid) begin
                    w_state_next = imem_ack ? S_FETCH : S_DROP;
                end else if (imem_ack) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD:  begin
                if (redirect_valid || if_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DROP:  begin
                if (imem_ack) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values of all registered outputs and the pc; everything holds by default.
    always_comb begin
        w_pc_next          = r_pc;
        w_imem_req_next    = r_imem_req;
        w_imem_addr_next   = r_imem_addr;
        w_if_valid_next    = r_if_valid;
        w_if_instr_next    = r_if_instr;
        w_if_pc_reg_next   = r_if_pc;
        w_if_pc_next_next  = r_if_pc_next;
        w_fetch_count_next = r_fetch_count;
        case (r_state)
            S_IDLE: begin
                w_pc_next        = redirect_valid ? redirect_target : r_pc;
                w_imem_addr_next = redirect_valid ? redirect_target : r_pc;
                w_imem_req_next  = 1'b1;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    // The address may only move once the pending request has completed.
                    w_pc_next = redirect_target;
                    if (imem_ack) begin
                        w_imem_addr_next = redirect_target;
                    end
                end else if (imem_ack) begin
                    w_if_instr_next   = imem_rdata;
                    w_if_pc_reg_next  = r_imem_addr;
                    w_if_pc_next_next = r_imem_addr + ONE;
                    w_if_valid_next   = 1'b1;
                    w_imem_req_next   = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_if_valid_next  = 1'b0;
                    w_pc_next        = redirect_target;
                    w_imem_addr_next = redirect_target;
                    w_imem_req_next  = 1'b1;
                end else if (if_ready) begin
                    w_if_valid_next    = 1'b0;
                    w_fetch_count_next = r_fetch_count + ONE;
                    w_pc_next          = w_pc_inc;
                    w_imem_addr_next   = w_pc_inc;
                    w_imem_req_next    = 1'b1;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_pc_next        = w_drop_sel;
                    w_imem_addr_next = w_drop_sel;
                end else if (redirect_valid) begin
                    w_pc_next = redirect_target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_next  <= '0;
            r_fetch_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_imem_req    <= w_imem_req_next;
            r_imem_addr   <= w_imem_addr_next;
            r_if_valid    <= w_if_valid_next;
            r_if_instr    <= w_if_instr_next;
            r_if_pc       <= w_if_pc_reg_next;
            r_if_pc_next  <= w_if_pc_next_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_next  = r_if_pc_next;
    assign fetch_count = r_fetch_count;

endmodule
